// File: rtl/lbp_stream_engine_if.sv
// Bus between the LBP engine, the gray image memory and the LBP result memory.
//   gray_ready : memory -> engine, image available (level)
//   gray_req   : engine -> memory, read strobe for gray_addr
//   gray_addr  : engine -> memory, raster read index
//   gray_data  : memory -> engine, pixel for the read issued the previous cycle
//   lbp_valid  : engine -> memory, write strobe for lbp_addr/lbp_data
//   lbp_addr   : engine -> memory, raster write index
//   lbp_data   : engine -> memory, LBP code
//   finish     : engine -> memory, all results written
interface lbp_stream_engine_if #(
  parameter int DW = 8,
  parameter int AW = 14
);
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [DW-1:0] gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [7:0]    lbp_data;
  logic          finish;

  // Memory side
  modport master (
    output gray_ready, gray_data,
    input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
  );

  // Engine side
  modport slave (
    input  gray_ready, gray_data,
    output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
  );
endinterface

// File: rtl/lbp_stream_engine.sv
// Streaming 3x3 Local Binary Pattern engine. Reads each gray pixel once in
// raster order, keeps the last 2*IMG_W+2 pixels in a shift-register line
// buffer and writes one LBP code per pixel address in raster order; border
// pixels are written as 0.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : gray read / LBP write / finish signals (lbp_stream_engine_if.slave)
//
// State | Meaning
// IDLE  | waiting for gray_ready
// RUN   | issuing reads 0..IMG_W*IMG_H-1 whenever gray_ready=1
// FLUSH | draining in-flight data, then writing the trailing border codes
// DONE  | all results written, finish held until reset
module lbp_stream_engine #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int DW     = 8,
  parameter int AW     = 14,
  parameter int THRESH = 0
) (
  input  logic              clk,
  input  logic              reset,
  lbp_stream_engine_if.slave bus
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = AW + 1;  // counters must reach NPIX itself
  localparam int SRL  = 2 * IMG_W + 2;
  localparam int CLW  = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);

  localparam logic [CW-1:0]  LAST_RD  = CW'(NPIX - 1);
  localparam logic [CW-1:0]  NPIX_C   = CW'(NPIX);
  localparam logic [CW-1:0]  FIRST_WR = CW'(IMG_W + 1);
  localparam logic [CW-1:0]  ONE_C    = CW'(1);
  localparam logic [CLW-1:0] COL_LAST = CLW'(IMG_W - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(IMG_H - 1);
  localparam logic [DW:0]    TH       = (DW+1)'(THRESH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  logic [CW-1:0]  r_rd_idx, r_in_idx, r_wr_idx;
  logic [CLW-1:0] r_wcol;
  logic [RW-1:0]  r_wrow;
  logic           r_req_d;
  logic           r_gray_req, r_lbp_valid, r_finish;
  logic [AW-1:0]  r_gray_addr, r_lbp_addr;
  logic [7:0]     r_lbp_data;
  logic [DW-1:0]  r_sr [SRL];

  logic           w_issue, w_pix_wr, w_flush_wr, w_any_wr, w_border;
  logic [DW-1:0]  w_nb [8];
  logic [DW:0]    w_thr;
  logic [7:0]     w_code;

  assign bus.gray_req  = r_gray_req;
  assign bus.gray_addr = r_gray_addr;
  assign bus.lbp_valid = r_lbp_valid;
  assign bus.lbp_addr  = r_lbp_addr;
  assign bus.lbp_data  = r_lbp_data;
  assign bus.finish    = r_finish;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.gray_ready) w_state_nxt = S_RUN;
      S_RUN: begin
        if (bus.gray_ready) begin
          w_issue = 1'b1;
          if (r_rd_idx == LAST_RD) w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: if (r_wr_idx == NPIX_C) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pixel i arriving now completes the window centred on k = i-IMG_W-1.
  assign w_pix_wr   = r_req_d && (r_in_idx >= FIRST_WR);
  // Trailing border writes start only once no read is pending or arriving.
  assign w_flush_wr = (r_state == S_FLUSH) && !r_gray_req && !r_req_d && (r_wr_idx != NPIX_C);
  assign w_any_wr   = w_pix_wr || w_flush_wr;
  assign w_border   = (r_wrow == '0) || (r_wrow == ROW_LAST) ||
                      (r_wcol == '0) || (r_wcol == COL_LAST);

  // r_sr[j] holds pixel i-1-j; the arriving pixel is the bottom-right neighbour.
  always_comb begin
    w_nb[0] = r_sr[2*IMG_W+1];
    w_nb[1] = r_sr[2*IMG_W];
    w_nb[2] = r_sr[2*IMG_W-1];
    w_nb[3] = r_sr[IMG_W+1];
    w_nb[4] = r_sr[IMG_W-1];
    w_nb[5] = r_sr[1];
    w_nb[6] = r_sr[0];
    w_nb[7] = bus.gray_data;
    w_thr   = {1'b0, r_sr[IMG_W]} + TH;
    w_code  = '0;
    for (int j = 0; j < 8; j++) w_code[j] = ({1'b0, w_nb[j]} >= w_thr);
  end

  always_ff @(posedge clk) begin
    if (r_req_d) begin
      r_sr[0] <= bus.gray_data;
      for (int j = 1; j < SRL; j++) r_sr[j] <= r_sr[j-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_idx    <= '0;
      r_in_idx    <= '0;
      r_wr_idx    <= '0;
      r_wcol      <= '0;
      r_wrow      <= '0;
      r_req_d     <= 1'b0;
      r_gray_req  <= 1'b0;
      r_gray_addr <= '0;
      r_lbp_valid <= 1'b0;
      r_lbp_addr  <= '0;
      r_lbp_data  <= '0;
      r_finish    <= 1'b0;
    end else begin
      r_gray_req <= w_issue;
      if (w_issue) begin
        r_gray_addr <= r_rd_idx[AW-1:0];
        r_rd_idx    <= r_rd_idx + ONE_C;
      end
      r_req_d <= r_gray_req;
      if (r_req_d) r_in_idx <= r_in_idx + ONE_C;
      r_lbp_valid <= w_any_wr;
      if (w_any_wr) begin
        r_lbp_addr <= r_wr_idx[AW-1:0];
        r_lbp_data <= (w_flush_wr || w_border) ? 8'h00 : w_code;
        r_wr_idx   <= r_wr_idx + ONE_C;
        if (r_wcol == COL_LAST) begin
          r_wcol <= '0;
          r_wrow <= r_wrow + RW'(1);
        end else begin
          r_wcol <= r_wcol + CLW'(1);
        end
      end
      r_finish <= (w_state_nxt == S_DONE);
    end
  end
endmodule

// File: tb/tb_lbp_stream_engine.sv
module tb_lbp_stream_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [4];
  logic rdy [4];

  // 0: 4x4 pixel=index; 1: 5x5 const 0x40 THRESH 0;
  // 2: 5x5 THRESH 1 (0x40 then 0xFF); 3: 128x128 random, ready toggling
  lbp_stream_engine_if #(.DW(8), .AW(4))  if_a ();
  lbp_stream_engine_if #(.DW(8), .AW(5))  if_b ();
  lbp_stream_engine_if #(.DW(8), .AW(5))  if_c ();
  lbp_stream_engine_if #(.DW(8), .AW(14)) if_d ();

  lbp_stream_engine #(.IMG_W(4), .IMG_H(4), .DW(8), .AW(4), .THRESH(0))
    u_a (.clk(clk), .reset(rst[0]), .bus(if_a.slave));
  lbp_stream_engine #(.IMG_W(5), .IMG_H(5), .DW(8), .AW(5), .THRESH(0))
    u_b (.clk(clk), .reset(rst[1]), .bus(if_b.slave));
  lbp_stream_engine #(.IMG_W(5), .IMG_H(5), .DW(8), .AW(5), .THRESH(1))
    u_c (.clk(clk), .reset(rst[2]), .bus(if_c.slave));
  lbp_stream_engine #(.IMG_W(128), .IMG_H(128), .DW(8), .AW(14), .THRESH(0))
    u_d (.clk(clk), .reset(rst[3]), .bus(if_d.slave));

  logic [7:0] img_a [16];
  logic [7:0] img_b [25];
  logic [7:0] img_c [25];
  logic [7:0] img_d [16384];

  assign if_a.gray_ready = rdy[0];
  assign if_b.gray_ready = rdy[1];
  assign if_c.gray_ready = rdy[2];
  assign if_d.gray_ready = rdy[3];

  // Gray memories: data returned the cycle after the request
  always @(posedge clk) if (if_a.gray_req) if_a.gray_data <= img_a[if_a.gray_addr];
  always @(posedge clk) if (if_b.gray_req) if_b.gray_data <= img_b[if_b.gray_addr];
  always @(posedge clk) if (if_c.gray_req) if_c.gray_data <= img_c[if_c.gray_addr];
  always @(posedge clk) if (if_d.gray_req) if_d.gray_data <= img_d[if_d.gray_addr];

  logic        v [4], fin [4], rq [4];
  logic [15:0] a [4], ra [4];
  logic [7:0]  d [4];

  assign v[0] = if_a.lbp_valid; assign a[0] = 16'(if_a.lbp_addr); assign d[0] = if_a.lbp_data;
  assign v[1] = if_b.lbp_valid; assign a[1] = 16'(if_b.lbp_addr); assign d[1] = if_b.lbp_data;
  assign v[2] = if_c.lbp_valid; assign a[2] = 16'(if_c.lbp_addr); assign d[2] = if_c.lbp_data;
  assign v[3] = if_d.lbp_valid; assign a[3] = 16'(if_d.lbp_addr); assign d[3] = if_d.lbp_data;
  assign fin[0] = if_a.finish; assign rq[0] = if_a.gray_req; assign ra[0] = 16'(if_a.gray_addr);
  assign fin[1] = if_b.finish; assign rq[1] = if_b.gray_req; assign ra[1] = 16'(if_b.gray_addr);
  assign fin[2] = if_c.finish; assign rq[2] = if_c.gray_req; assign ra[2] = 16'(if_c.gray_addr);
  assign fin[3] = if_d.finish; assign rq[3] = if_d.gray_req; assign ra[3] = 16'(if_d.gray_addr);

  logic [23:0] exp_q [4][$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs(input int i);
    return {21'd0, rq[i], ra[i], v[i], a[i], d[i], fin[i]};
  endfunction

  // Reference LBP for the 128x128 image, THRESH=0
  function automatic logic [7:0] lbp_ref(input int k);
    int r, c;
    int dr [8];
    int dc [8];
    logic [7:0] code;
    dr = '{-1, -1, -1, 0, 0, 1, 1, 1};
    dc = '{-1, 0, 1, -1, 1, -1, 0, 1};
    r = k / 128;
    c = k % 128;
    code = 8'h00;
    if (r == 0 || r == 127 || c == 0 || c == 127) return 8'h00;
    for (int j = 0; j < 8; j++)
      if (img_d[(r + dr[j]) * 128 + c + dc[j]] >= img_d[k]) code[j] = 1'b1;
    return code;
  endfunction

  task automatic push_d();
    for (int k = 0; k < 16384; k++) exp_q[3].push_back({16'(k), lbp_ref(k)});
  endtask

  task automatic push_c_zero();
    for (int k = 0; k < 25; k++) exp_q[2].push_back({16'(k), 8'h00});
  endtask

  logic fin_prev [4], v_prev [4], seen [4], gap [4];

  task automatic monitor_loop();
    int cyc = 0;
    int rd6_cyc = 0;
    logic b_first = 1'b0;
    logic [23:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (rst[i]) begin
          fin_prev[i] = 1'b0; v_prev[i] = 1'b0; seen[i] = 1'b0; gap[i] = 1'b0;
        end else begin
          if (v[i]) begin
            if (exp_q[i].size() == 0) check($sformatf("extra_write_dut%0d", i), {40'd0, a[i], d[i]}, 64'd0);
            else begin
              e = exp_q[i].pop_front();
              check($sformatf("write_dut%0d", i), {40'd0, a[i], d[i]}, {40'd0, e});
            end
            if (seen[i] && !v_prev[i]) gap[i] = 1'b1;
            seen[i] = 1'b1;
          end
          if (fin[i] && !fin_prev[i]) begin
            check($sformatf("finish_lag_dut%0d", i), 64'(v_prev[i]), 64'd1);
            check($sformatf("all_written_dut%0d", i), 64'(exp_q[i].size()), 64'd0);
            if (i != 3) check($sformatf("writes_back_to_back_dut%0d", i), 64'(gap[i]), 64'd0);
          end
          if (fin[i]) check($sformatf("done_quiet_dut%0d", i), {62'd0, v[i], rq[i]}, 64'd0);
          fin_prev[i] = fin[i];
          v_prev[i]   = v[i];
        end
      end
      if (!rst[1]) begin
        if (rq[1] && ra[1] == 16'd6) rd6_cyc = cyc;
        if (v[1] && !b_first) begin
          b_first = 1'b1;
          check("first_write_latency", 64'(cyc - rd6_cyc), 64'd2);
        end
      end
    end
  endtask

  initial begin
    int k;
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; rdy[i] = 1'b0;
      fin_prev[i] = 1'b0; v_prev[i] = 1'b0; seen[i] = 1'b0; gap[i] = 1'b0;
    end
    for (int i = 0; i < 16; i++) img_a[i] = 8'(i);
    for (int i = 0; i < 25; i++) begin img_b[i] = 8'h40; img_c[i] = 8'h40; end
    for (int i = 0; i < 16384; i++) img_d[i] = 8'($urandom_range(0, 255));

    // pixel=index: every centre is above its upper/left neighbours, so only b4..b7 set
    for (int i = 0; i < 16; i++)
      exp_q[0].push_back({16'(i), (i == 5 || i == 6 || i == 9 || i == 10) ? 8'hF0 : 8'h00});
    for (int i = 0; i < 25; i++)
      exp_q[1].push_back({16'(i), (i / 5 >= 1 && i / 5 <= 3 && i % 5 >= 1 && i % 5 <= 3) ? 8'hFF : 8'h00});
    push_c_zero();
    push_d();

    fork
      monitor_loop();
      forever begin
        @(negedge clk);
        rdy[3] = ($urandom_range(0, 9) < 6);
      end
    join_none

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) check($sformatf("reset_outputs_dut%0d", i), outs(i), 64'd0);
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("idle_without_ready_dut%0d", i), outs(i), 64'd0);
    for (int i = 0; i < 3; i++) rdy[i] = 1'b1;

    k = 0;
    while (!fin[2] && k < 500) begin @(negedge clk); k++; end
    check("dut2_first_run_done", 64'(fin[2]), 64'd1);
    img_c = '{default: 8'hFF};
    rst[2] = 1'b1;
    #1;
    check("reset_clears_finish_dut2", outs(2), 64'd0);
    exp_q[2].delete();
    push_c_zero();
    repeat (3) @(negedge clk);
    rst[2] = 1'b0;

    k = 0;
    while (ra[3] < 16'd3000 && k < 20000) begin @(negedge clk); k++; end
    check("dut3_reached_read_3000", 64'(k < 20000), 64'd1);
    @(posedge clk);
    #2;
    rst[3] = 1'b1;
    #1;
    check("async_reset_mid_run_dut3", outs(3), 64'd0);
    exp_q[3].delete();
    push_d();
    repeat (4) @(negedge clk);
    rst[3] = 1'b0;

    k = 0;
    while (!(fin[0] && fin[1] && fin[2] && fin[3]) && k < 90000) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("finish_held_dut%0d", i), 64'(fin[i]), 64'd1);
      check($sformatf("queue_drained_dut%0d", i), 64'(exp_q[i].size()), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
